// File: rtl/cpu_port_pkg.sv
// Shared constants and helpers for the CPU I/O port bank.
package cpu_port_pkg;

    // Register offsets within one port's 4-byte slot.
    localparam logic [1:0] OFS_DIR  = 2'd0;
    localparam logic [1:0] OFS_DATA = 2'd1;
    localparam logic [1:0] OFS_MASK = 2'd2;
    localparam logic [1:0] OFS_FLAG = 2'd3;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/port_sync_edge.sv
// Input synchroniser chain followed by a "previous" flop; flags per-bit transitions.
module port_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] change
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Shift pins through the synchroniser; prev holds last cycle's synced value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
            prev_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync   = stage_q[SYNC_STAGES-1];
    assign change = sync ^ prev_q;

endmodule

// File: rtl/cpu_port_bank.sv
// Bank of PORTS I/O ports of WIDTH bits, memory-mapped at BASE in the CPU address space.
// Each port: DIR, DATA, MASK and sticky FLAG registers; change interrupt; bus echo on writes.
module cpu_port_bank
    import cpu_port_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       PORTS       = 1,
    parameter int unsigned       ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE        = '0,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   we,
    input  logic [WIDTH-1:0]       core_wdata,
    input  logic [WIDTH-1:0]       bus_rdata,
    output logic [WIDTH-1:0]       core_rdata,
    output logic [WIDTH-1:0]       bus_wdata,
    output logic                   hit,
    input  logic [PORTS*WIDTH-1:0] port_in,
    output logic [PORTS*WIDTH-1:0] port_out,
    output logic [PORTS*WIDTH-1:0] port_dir,
    output logic                   irq_n
);

    localparam int unsigned PB = clog2(PORTS);
    localparam int unsigned WIN_LSB = 2 + PB;
    localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'((1 << PB) - 1);

    logic [WIDTH-1:0] dir_q  [PORTS];
    logic [WIDTH-1:0] data_q [PORTS];
    logic [WIDTH-1:0] mask_q [PORTS];
    logic [WIDTH-1:0] flag_q [PORTS];
    logic [WIDTH-1:0] flag_d [PORTS];
    logic [WIDTH-1:0] sync_in [PORTS];
    logic [WIDTH-1:0] chg    [PORTS];
    logic [PORTS-1:0] wr_sel;
    logic [ADDR_W-1:0] addr_idx;
    logic [1:0]        ofs;
    logic [WIDTH-1:0]  port_rd;
    logic [WIDTH-1:0]  last_q;
    logic              irq_any;
    logic              irq_n_q;

    assign hit      = (addr >> WIN_LSB) == (BASE >> WIN_LSB);
    assign addr_idx = (addr >> 2) & IDX_MASK;
    assign ofs      = addr[1:0];

    for (genvar p = 0; p < int'(PORTS); p++) begin : g_port
        port_sync_edge #(
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .din   (port_in[p*WIDTH +: WIDTH]),
            .sync  (sync_in[p]),
            .change(chg[p])
        );
        assign port_out[p*WIDTH +: WIDTH] = data_q[p];
        assign port_dir[p*WIDTH +: WIDTH] = dir_q[p];
    end

    // Read mux; indices at or beyond PORTS match no port and read as zero.
    always_comb begin
        port_rd = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (addr_idx == ADDR_W'(p)) begin
                unique case (ofs)
                    OFS_DIR:  port_rd = dir_q[p];
                    OFS_DATA: port_rd = (dir_q[p] & data_q[p]) | (~dir_q[p] & sync_in[p]);
                    OFS_MASK: port_rd = mask_q[p];
                    OFS_FLAG: port_rd = flag_q[p];
                endcase
            end
        end
        core_rdata = (hit && !we) ? port_rd : bus_rdata;
    end

    // Write strobes and flag next-state; a set in the same cycle as a clear wins.
    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            wr_sel[p] = enable && we && hit && (addr_idx == ADDR_W'(p));
            flag_d[p] = flag_q[p] & ~((wr_sel[p] && ofs == OFS_FLAG) ? core_wdata : '0);
            flag_d[p] = flag_d[p] | (chg[p] & ~dir_q[p]);
        end
    end

    // CPU-visible register writes, gated by the cycle enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < int'(PORTS); p++) begin
                dir_q[p]  <= '0;
                data_q[p] <= '0;
                mask_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(PORTS); p++) begin
                if (wr_sel[p]) begin
                    case (ofs)
                        OFS_DIR:  dir_q[p]  <= core_wdata;
                        OFS_DATA: data_q[p] <= core_wdata;
                        OFS_MASK: mask_q[p] <= core_wdata;
                        default:  ;
                    endcase
                end
            end
        end
    end

    // Sticky change flags run every clock; only the clear side depends on enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < int'(PORTS); p++) flag_q[p] <= '0;
        end else begin
            for (int p = 0; p < int'(PORTS); p++) flag_q[p] <= flag_d[p];
        end
    end

    // OR-reduce enabled flags across all ports.
    always_comb begin
        irq_any = 1'b0;
        for (int unsigned p = 0; p < PORTS; p++) irq_any = irq_any | (|(flag_q[p] & mask_q[p]));
    end

    // Registered active-low interrupt.
    always_ff @(posedge clk) begin
        if (reset) irq_n_q <= 1'b1;
        else       irq_n_q <= ~irq_any;
    end

    assign irq_n = irq_n_q;

    // Last-read latch: whatever the core last read, echoed onto the bus during port writes.
    always_ff @(posedge clk) begin
        if (reset)               last_q <= '0;
        else if (enable && !we)  last_q <= core_rdata;
    end

    assign bus_wdata = (hit && we) ? last_q : core_wdata;

endmodule

// File: tb/tb_cpu_port_bank.sv
// Scoreboard bench for cpu_port_bank: stimulus queues expectations, a monitor compares them.
module tb_cpu_port_bank;

    localparam int S_RDATA = 0, S_POUT = 1, S_PDIR = 2, S_IRQ = 3, S_BWD = 4, S_HIT = 5;
    localparam int W_RDATA = 6, W_HIT = 7, W_POUT = 8, W_PDIR = 9;

    logic        clk = 1'b0;
    logic        reset, enable, we;
    logic [15:0] addr, w_addr;
    logic [7:0]  core_wdata, bus_rdata;
    logic [7:0]  core_rdata, bus_wdata, w_core_rdata, w_bus_wdata;
    logic        hit, w_hit, irq_n, w_irq_n;
    logic [15:0] port_in, port_out, port_dir;
    logic [23:0] w_port_in, w_port_out, w_port_dir;
    logic        obs_valid;

    typedef struct {
        int          sig;
        logic [23:0] val;
        string       name;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_port_bank #(
        .WIDTH(8), .PORTS(2), .ADDR_W(16), .BASE(16'h0000), .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr), .we(we),
        .core_wdata(core_wdata), .bus_rdata(bus_rdata), .core_rdata(core_rdata),
        .bus_wdata(bus_wdata), .hit(hit), .port_in(port_in), .port_out(port_out),
        .port_dir(port_dir), .irq_n(irq_n)
    );

    cpu_port_bank #(
        .WIDTH(8), .PORTS(3), .ADDR_W(16), .BASE(16'hFD00), .SYNC_STAGES(2)
    ) u_win (
        .clk(clk), .reset(reset), .enable(enable), .addr(w_addr), .we(we),
        .core_wdata(core_wdata), .bus_rdata(bus_rdata), .core_rdata(w_core_rdata),
        .bus_wdata(w_bus_wdata), .hit(w_hit), .port_in(w_port_in), .port_out(w_port_out),
        .port_dir(w_port_dir), .irq_n(w_irq_n)
    );

    function automatic logic [23:0] sample(input int sig);
        case (sig)
            S_RDATA: return {16'h0, core_rdata};
            S_POUT:  return {8'h0, port_out};
            S_PDIR:  return {8'h0, port_dir};
            S_IRQ:   return {23'h0, irq_n};
            S_BWD:   return {16'h0, bus_wdata};
            S_HIT:   return {23'h0, hit};
            W_RDATA: return {16'h0, w_core_rdata};
            W_HIT:   return {23'h0, w_hit};
            W_POUT:  return w_port_out;
            W_PDIR:  return w_port_dir;
            default: return 24'hxxxxxx;
        endcase
    endfunction

    // Monitor: on each presented observation, drain the scoreboard against the DUT.
    always @(negedge clk) begin
        if (obs_valid) begin
            while (q.size() > 0) begin
                automatic chk_t c = q.pop_front();
                automatic logic [23:0] act = sample(c.sig);
                checks++;
                if (act !== c.val) begin
                    errors++;
                    $display("FAIL %s actual %0h required %0h", c.name, act, c.val);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int sig, input logic [23:0] val, input string name);
        chk_t c;
        c.sig = sig;
        c.val = val;
        c.name = name;
        q.push_back(c);
    endtask

    task automatic observe();
        obs_valid = 1'b1;
        @(negedge clk);
        #1;
        obs_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        core_wdata = d;
        we = 1'b1;
        enable = 1'b1;
        step();
        we = 1'b0;
        enable = 1'b0;
        addr = 16'h0100;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; we = 1'b0; addr = 16'h0100; w_addr = 16'h0000;
        core_wdata = '0; bus_rdata = '0; port_in = '0; w_port_in = '0; obs_valid = 1'b0;
        step(); step(); step();
        reset = 1'b0;

        // Reset state
        expect_val(S_POUT, 24'h0, "rst_port_out");
        expect_val(S_PDIR, 24'h0, "rst_port_dir");
        expect_val(S_IRQ, 24'h1, "rst_irq_n");
        observe();
        for (int a = 0; a < 8; a++) begin
            addr = 16'(a);
            expect_val(S_RDATA, 24'h0, $sformatf("rst_read_%0d", a));
            observe();
        end
        addr = 16'h0100;

        // DIR/DATA mix: (A5 & 0F) | (3C & F0) = 35; bits 4,5 change with DIR=0 -> FLAG 30
        wr(16'h0000, 8'h0F);
        wr(16'h0001, 8'hA5);
        port_in = 16'h003C;
        step(); step(); step();
        addr = 16'h0001;
        expect_val(S_RDATA, 24'h35, "data_mix");
        expect_val(S_POUT, 24'h00A5, "port_out");
        expect_val(S_PDIR, 24'h000F, "port_dir");
        observe();
        addr = 16'h0003;
        expect_val(S_RDATA, 24'h30, "flag_read");
        expect_val(S_IRQ, 24'h1, "irq_unmasked");
        observe();
        wr(16'h0003, 8'hFF);
        addr = 16'h0003;
        expect_val(S_RDATA, 24'h00, "flag_cleared");
        observe();

        // Latency: bit 7 toggled, read after 2 edges, irq_n falls at edge 4
        wr(16'h0002, 8'h80);
        port_in = 16'h00BC;
        addr = 16'h0001;
        expect_val(S_RDATA, 24'h35, "lat_e0");
        observe();
        step();
        expect_val(S_RDATA, 24'h35, "lat_e1");
        observe();
        step();
        expect_val(S_RDATA, 24'hB5, "lat_e2");
        expect_val(S_IRQ, 24'h1, "irq_e2");
        observe();
        step();
        expect_val(S_IRQ, 24'h1, "irq_e3");
        observe();
        step();
        expect_val(S_IRQ, 24'h0, "irq_e4");
        observe();

        // Clear race: change pulse on bit 7 coincides with W1C of bit 7
        port_in = 16'h003C;
        step(); step();
        wr(16'h0003, 8'h80);
        addr = 16'h0003;
        expect_val(S_RDATA, 24'h80, "race_flag");
        expect_val(S_IRQ, 24'h0, "race_irq");
        observe();
        step();
        expect_val(S_IRQ, 24'h0, "race_irq_hold");
        observe();
        wr(16'h0003, 8'h80);
        addr = 16'h0003;
        expect_val(S_RDATA, 24'h00, "clr_flag");
        observe();
        step();
        expect_val(S_IRQ, 24'h1, "clr_irq");
        observe();

        // Bus echo
        addr = 16'h0100; bus_rdata = 8'h12; enable = 1'b1;
        expect_val(S_RDATA, 24'h12, "bus_passthru");
        observe();
        step();
        enable = 1'b0;
        addr = 16'h0005; we = 1'b1; core_wdata = 8'hFF;
        expect_val(S_BWD, 24'h12, "bus_echo");
        expect_val(S_HIT, 24'h1, "hit_in");
        observe();
        enable = 1'b1;
        step();
        enable = 1'b0; we = 1'b0;
        expect_val(S_POUT, 24'hFFA5, "port1_data");
        observe();
        addr = 16'h0100; we = 1'b1; core_wdata = 8'h77;
        expect_val(S_BWD, 24'h77, "bus_nohit");
        expect_val(S_HIT, 24'h0, "hit_out");
        observe();
        we = 1'b0; addr = 16'h0001; enable = 1'b1;
        step();
        enable = 1'b0; addr = 16'h0005; we = 1'b1;
        expect_val(S_BWD, 24'h35, "bus_echo_port");
        observe();
        we = 1'b0; addr = 16'h0100;

        // Window and index on the 3-port instance at FD00
        w_addr = 16'hFD0D; we = 1'b1; enable = 1'b1; core_wdata = 8'h5A;
        step();
        we = 1'b0; enable = 1'b0;
        expect_val(W_POUT, 24'h0, "win_p3_out");
        expect_val(W_PDIR, 24'h0, "win_p3_dir");
        expect_val(W_RDATA, 24'h0, "win_p3_read");
        expect_val(W_HIT, 24'h1, "win_p3_hit");
        observe();
        w_addr = 16'hFD10;
        expect_val(W_HIT, 24'h0, "win_out_hit");
        expect_val(W_RDATA, 24'h12, "win_out_read");
        observe();
        w_addr = 16'hFD09; we = 1'b1; enable = 1'b1;
        step();
        we = 1'b0; enable = 1'b0; w_addr = 16'h0000;
        expect_val(W_POUT, 24'h5A0000, "win_p2_data");
        observe();

        // Reset beats a write in the same cycle
        addr = 16'h0001; we = 1'b1; enable = 1'b1; core_wdata = 8'h33; reset = 1'b1;
        step();
        reset = 1'b0; we = 1'b0; enable = 1'b0; addr = 16'h0100;
        expect_val(S_POUT, 24'h0, "reset_wins_out");
        expect_val(S_PDIR, 24'h0, "reset_wins_dir");
        expect_val(S_IRQ, 24'h1, "reset_wins_irq");
        observe();

        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_port_bank.md
# cpu_port_bank

Parametrised on-chip I/O port bank for the 8501-class CPU shell. It generalises the single 8-bit port at $0000/$0001 to PORTS ports of WIDTH bits at a configurable base address. Each port adds synchronised inputs, per-bit change detection with maskable interrupt, and reproduction of the "last read byte" bus value during port writes. It sits between the CPU core's address/data/we signals and the external data bus, in parallel with the core-data-in mux.

## Interface
Parameters:
- WIDTH, 8: bits per port
- PORTS, 1: number of ports (1..8)
- ADDR_W, 16: CPU address width
- BASE, 16'h0000: base address; aligned to 4*PORTS rounded up to a power of two
- SYNC_STAGES, 2: input synchroniser depth (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  CPU cycle enable; registers update only when high
- addr  in  ADDR_W  core address
- we  in  1  core write strobe (1 = write)
- core_wdata  in  WIDTH  core data out
- bus_rdata  in  WIDTH  external data bus (read)
- core_rdata  out  WIDTH  data to core: port register on hit & ~we, else bus_rdata
- bus_wdata  out  WIDTH  data driven to external bus on writes
- hit  out  1  addr falls in the port window
- port_in  in  PORTS*WIDTH  pin inputs, port p at [p*WIDTH +: WIDTH]
- port_out  out  PORTS*WIDTH  data registers
- port_dir  out  PORTS*WIDTH  direction registers (1 = output)
- irq_n  out  1  active-low change interrupt

## Operation
- Window: PB = clog2(PORTS). hit = addr[ADDR_W-1:2+PB] == BASE[ADDR_W-1:2+PB]. Port index p = addr[2+PB-1:2]; p >= PORTS reads 0, writes ignored. Register offset r = addr[1:0].
- Per-port registers:
  - r=0: DIR, R/W.
  - r=1: DATA. Write sets the data register. Read returns, per bit, DIR ? data : synced input.
  - r=2: MASK, R/W interrupt enable.
  - r=3: FLAG. Read returns the sticky change flags; write-1-to-clear.
- Input path: port_in passes through SYNC_STAGES flops, then one more "previous" flop. A bit changes when sync != prev. FLAG bit sets on a change only while that DIR bit is 0.
- Simultaneous set and clear of the same FLAG bit: set wins.
- irq_n = ~|(FLAG & MASK) over all ports, registered.
- Last-read latch: on enable & ~we, the latch captures core_rdata, including port reads.
- bus_wdata = last-read latch when hit & we, else core_wdata. This generalises the 8501 behaviour of showing $00/$01 on the bus.
- Reset values: DIR=0, DATA=0, MASK=0, FLAG=0, sync/prev flops=0, last-read latch=0. Resulting outputs: port_out=0, port_dir=0, irq_n=1.
- Reset mid-operation wins over any write in the same cycle.
- Changes from reset-released zeroes may set FLAG after reset, but MASK=0 keeps irq_n high.

## Timing
- Register writes take effect on the clk edge where enable & we & hit. The new value is visible on port_out/port_dir and on reads the next cycle.
- core_rdata, hit and bus_wdata are combinational from addr/we/registers.
- Pin-to-read latency: a port_in change is visible in a DATA read after SYNC_STAGES clk edges.
- Pin-to-FLAG latency: SYNC_STAGES+1 edges.
- Pin-to-irq_n latency: SYNC_STAGES+2 edges.
- Sync, prev, FLAG set and irq_n run every clk, independent of enable. FLAG clear, register writes and the last-read latch require enable.
- Changing DIR from 1 to 0 does not by itself set FLAG; only subsequent sync transitions do.

## Structure
- Package cpu_port_pkg holds:
  - offset constants OFS_DIR=0, OFS_DATA=1, OFS_MASK=2, OFS_FLAG=3
  - a clog2 function
- Sub-module port_sync_edge (WIDTH, SYNC_STAGES): synchroniser plus prev flop. Outputs the synced value and a per-bit change pulse. Instantiated once per port.
- The top level holds decode, register arrays, read mux, last-read latch and irq reduction.

## Test plan
- Reset: assert reset with WIDTH=8, PORTS=2 -> port_out=0, port_dir=0, irq_n=1; reads of $0000..$0007 return 0.
- DIR/DATA: write DIR=$0F and DATA=$A5 to port 0, drive port_in=$3C -> read DATA returns $35; port_out=$A5.
- Latency: toggle port_in bit 7 with DIR=0 -> DATA read reflects it after exactly 2 edges. With MASK=$80, irq_n falls at edge 4.
- Flag clear race: FLAG bit 7 set; write $80 to FLAG in the same cycle as a new bit-7 change -> FLAG bit 7 remains 1 and irq_n stays 0. A later clear with no change -> irq_n=1 next cycle.
- Bus echo: read $12 from external bus, then write $FF to port 1 DATA ($0005) -> bus_wdata=$12. A write outside the window -> bus_wdata=core_wdata.
- Window/index: BASE=$FD00, PORTS=3; write $FD0D (port 3) -> no register changes, read returns 0. $FD10 -> hit=0, core_rdata=bus_rdata.
